calc_exec: RTL and testbench

- Execution unit for the calculator datapath.
- Consumes the 3-bit opcode produced by the button-select encoder (IDLE/ADD/SUB/MUL/XOR) plus two operands, and performs the operation.
- ADD, SUB and XOR complete in one cycle. MUL uses a sequential shift-add loop.
- Start/busy/done handshake toward the display/control logic.

---
 rtl/calc_exec.sv | 111 +++++++++++
 tb/tb_calc_exec.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/calc_exec.sv
// rtl/calc_exec.sv - calculator execution unit: single-cycle ADD/SUB/XOR, sequential shift-add MUL
module calc_exec #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 err
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   acc, mcand, acc_sum;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic [WIDTH:0]       sum, diff;
  logic                 accept, mul_last;

  assign accept   = (state == S_IDLE) && start;
  assign mul_last = (state == S_MUL) && (cnt == CW'(WIDTH - 1));
  assign sum      = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is the borrow, i.e. a < b.
  assign diff     = {1'b0, a} - {1'b0, b};
  assign acc_sum  = mplier[0] ? (acc + mcand) : acc;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (op == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (mul_last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
      carry  <= 1'b0;
      err    <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      case (op)
        OP_ADD: begin
          result <= {{(WIDTH-1){1'b0}}, sum};
          carry  <= sum[WIDTH];
          err    <= 1'b0;
        end
        OP_SUB: begin
          result <= {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
          carry  <= diff[WIDTH];
          err    <= 1'b0;
        end
        OP_MUL: begin
          // Outputs keep their old values until the product is complete.
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          cnt    <= '0;
        end
        OP_XOR: begin
          result <= {{WIDTH{1'b0}}, a ^ b};
          carry  <= 1'b0;
          err    <= 1'b0;
        end
        default: begin
          result <= '0;
          carry  <= 1'b0;
          err    <= 1'b1;
        end
      endcase
    end else if (state == S_MUL) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (mul_last) begin
        result <= acc_sum;
        carry  <= 1'b0;
        err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_exec.sv
// tb/tb_calc_exec.sv - vector-table and randomized check of calc_exec against an arithmetic model
module tb_calc_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [7:0]  a, b;
  logic        start;
  logic        busy, done, carry, err;
  logic [15:0] result;

  int n_vec = 0;
  int n_bad = 0;

  calc_exec #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .op(op), .a(a), .b(b), .start(start),
    .busy(busy), .done(done), .result(result), .carry(carry), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    vec_t v;
    int   s;
    v.op = o; v.a = x; v.b = y;
    v.res = 16'd0; v.c = 1'b0; v.e = 1'b0; v.lat = 1;
    case (o)
      3'd1: begin s = int'(x) + int'(y); v.res = 16'(s); v.c = (s > 255); end
      3'd2: begin s = int'(x) - int'(y); v.res = 16'(s & 255); v.c = (int'(x) < int'(y)); end
      3'd3: begin v.res = 16'(int'(x) * int'(y)); v.lat = 9; end
      3'd4: v.res = 16'(int'(x ^ y));
      default: v.e = 1'b1;
    endcase
    return v;
  endfunction

  function automatic vec_t mk(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                              input logic [15:0] r, input logic c, input logic e, input int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r; v.c = c; v.e = e; v.lat = l;
    return v;
  endfunction

  // Issue one operation, scramble the operand inputs after acceptance, and measure latency to done.
  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output int busy_gaps);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    busy_gaps = 0;
    while (!done && lat < 20) begin
      if (!busy) busy_gaps++;
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_gaps++;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int      lat, gaps, dones;
    vec_t    v;
    logic [15:0] held;

    rst = 1'b0; start = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0;
    repeat (3) @(negedge clk);
    check("reset result", 32'(result), 32'd0);
    check("reset flags", {28'd0, busy, done, carry, err}, 32'd0);
    rst = 1'b1;

    vecs.push_back(mk(3'd1, 8'd200, 8'd100, 16'd300,  1'b1, 1'b0, 1));
    vecs.push_back(mk(3'd2, 8'd5,   8'd7,   16'h00FE, 1'b1, 1'b0, 1));
    vecs.push_back(mk(3'd2, 8'd7,   8'd5,   16'h0002, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'd3, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 9));
    vecs.push_back(mk(3'd3, 8'd0,   8'd13,  16'h0000, 1'b0, 1'b0, 9));
    vecs.push_back(mk(3'd4, 8'hA5,  8'h0F,  16'h00AA, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'd6, 8'h12,  8'h34,  16'h0000, 1'b0, 1'b1, 1));
    vecs.push_back(mk(3'd1, 8'd1,   8'd2,   16'd3,    1'b0, 1'b0, 1));
    vecs.push_back(mk(3'd0, 8'd9,   8'd9,   16'h0000, 1'b0, 1'b1, 1));
    vecs.push_back(mk(3'd3, 8'd128, 8'd2,   16'd256,  1'b0, 1'b0, 9));
    for (int i = 0; i < 40; i++)
      vecs.push_back(model(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)));

    foreach (vecs[i]) begin
      v = vecs[i];
      run_op(v.op, v.a, v.b, lat, gaps);
      check($sformatf("v%0d op%0d latency", i, v.op), 32'(lat), 32'(v.lat));
      check($sformatf("v%0d busy while active", i), 32'(gaps), 32'd0);
      check($sformatf("v%0d result", i), 32'(result), 32'(v.res));
      check($sformatf("v%0d carry/err", i), {30'd0, carry, err}, {30'd0, v.c, v.e});
      @(negedge clk);
      check($sformatf("v%0d idle after done", i), {30'd0, busy, done}, 32'd0);
    end

    held = result;
    repeat (4) @(negedge clk);
    check("idle hold result", 32'(result), 32'(held));
    check("idle hold done", 32'(done), 32'd0);

    // A start pulse during MUL must be dropped, not queued.
    @(negedge clk);
    op = 3'd3; a = 8'd12; b = 8'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; lat = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin op = 3'd1; a = 8'd50; b = 8'd60; start = 1'b1; end
      if (c == 4) start = 1'b0;
      if (done) begin dones++; if (lat == 0) lat = c; end
      if (c == 9) check("mul ignore result", 32'(result), 32'd132);
      @(negedge clk);
    end
    check("mul ignore done count", 32'(dones), 32'd1);
    check("mul ignore latency", 32'(lat), 32'd9);
    check("mul ignore final result", 32'(result), 32'd132);

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = 3'd3; a = 8'd100; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid-mul reset result", 32'(result), 32'd0);
    check("mid-mul reset flags", {28'd0, busy, done, carry, err}, 32'd0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no done after reset", 32'(dones), 32'd0);
    rst = 1'b1;
    run_op(3'd1, 8'd1, 8'd1, lat, gaps);
    check("post-reset add latency", 32'(lat), 32'd1);
    check("post-reset add result", 32'(result), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
